// File: rtl/bist_compare_ctrl_if.sv
// Bus between the BIST sequencer, the pattern ROM / array launch logic and
// the column comparator. The slave modport is the sequencer's view.
interface bist_compare_ctrl_if #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int MAX_PATTERNS      = 16
);
  localparam int NPW  = $clog2(MAX_PATTERNS) + 1;
  localparam int IDXW = $clog2(MAX_PATTERNS);
  localparam int FCW  = $clog2(SYSTOLIC_SIZE) + 1;

  logic                         start;
  logic [NPW-1:0]               num_patterns;
  logic [IDXW-1:0]              pattern_idx;
  logic                         pattern_launch;
  logic                         array_done;
  logic [PARTIAL_SUM_WIDTH-1:0] golden_answer;
  logic [PARTIAL_SUM_WIDTH-1:0] correct_answer;
  logic [SYSTOLIC_SIZE-1:0]     compared_results;
  logic [SYSTOLIC_SIZE-1:0]     fault_map;
  logic [FCW-1:0]               fault_count;
  logic                         busy;
  logic                         done;
  logic                         timeout_err;

  modport slave (
    input  start, num_patterns, array_done, golden_answer, compared_results,
    output pattern_idx, pattern_launch, correct_answer, fault_map, fault_count,
           busy, done, timeout_err
  );

  modport master (
    output start, num_patterns, array_done, golden_answer, compared_results,
    input  pattern_idx, pattern_launch, correct_answer, fault_map, fault_count,
           busy, done, timeout_err
  );
endinterface

// File: rtl/bist_compare_ctrl.sv
// BIST sequencer for the systolic array: launches each test pattern, drives
// the golden answer to the column comparator, and accumulates a sticky
// per-column fault map for the column-remap logic.
module bist_compare_ctrl #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int MAX_PATTERNS      = 16,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                clk,
  input  logic                rst,
  bist_compare_ctrl_if.slave  bus
);
  localparam int NPW  = $clog2(MAX_PATTERNS) + 1;
  localparam int IDXW = $clog2(MAX_PATTERNS);
  localparam int FCW  = $clog2(SYSTOLIC_SIZE) + 1;
  localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CMP, S_SAMPLE, S_FINISH
  } state_t;

  state_t                       r_state;
  logic [NPW-1:0]               r_num;
  logic [IDXW-1:0]              r_idx;
  logic                         r_launch;
  logic [PARTIAL_SUM_WIDTH-1:0] r_ca;
  logic [SYSTOLIC_SIZE-1:0]     r_fmap;
  logic [FCW-1:0]               r_fcnt;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_tmo;
  logic [TCW-1:0]               r_tcnt;

  logic w_num_ok;
  logic w_last;
  logic w_tmo_hit;

  function automatic logic [FCW-1:0] popcount(input logic [SYSTOLIC_SIZE-1:0] v);
    logic [FCW-1:0] c;
    c = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) c = c + FCW'(v[i]);
    return c;
  endfunction

  assign w_num_ok  = (bus.num_patterns != '0) && (bus.num_patterns <= NPW'(MAX_PATTERNS));
  assign w_last    = ({1'b0, r_idx} == (r_num - NPW'(1)));
  // The last WAIT cycle before expiry; array_done in that cycle still wins.
  assign w_tmo_hit = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  // Run sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_num    <= '0;
      r_idx    <= '0;
      r_launch <= 1'b0;
      r_ca     <= '0;
      r_fmap   <= '0;
      r_fcnt   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_launch <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_fmap <= '0;
          r_fcnt <= '0;
          r_tmo  <= 1'b0;
          if (w_num_ok) begin
            r_num    <= bus.num_patterns;
            r_idx    <= '0;
            r_launch <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_LAUNCH;
          end else begin
            // Bad pattern count: report an empty, clean run.
            r_done <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_ca    <= bus.golden_answer;
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.array_done) begin
            r_state <= S_CMP;
          end else if (w_tmo_hit) begin
            // Array never answered: mark every column suspect.
            r_tmo   <= 1'b1;
            r_fmap  <= '1;
            r_state <= S_FINISH;
          end else begin
            r_tcnt <= r_tcnt + TCW'(1);
          end
        end
        S_CMP: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_fmap <= r_fmap | bus.compared_results;
          if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_idx    <= r_idx + IDXW'(1);
            r_launch <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_FINISH: begin
          r_fcnt  <= popcount(r_fmap);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pattern_idx    = r_idx;
  assign bus.pattern_launch = r_launch;
  assign bus.correct_answer = r_ca;
  assign bus.fault_map      = r_fmap;
  assign bus.fault_count    = r_fcnt;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.timeout_err    = r_tmo;
endmodule
